// File: rtl/pc_ctrl_fsm.sv
// Multi-cycle control sequencer: fetch, decode, memory wait, writeback and
// interrupt entry, with strobes decoded combinationally from state and inputs.
module pc_ctrl_fsm (
  input  logic       CLK,
  input  logic       RST,
  input  logic       INTR,
  input  logic       MIE,
  input  logic [6:0] OPCODE,
  input  logic [2:0] FUNCT3,
  input  logic       BR_TAKEN,
  input  logic       MEM_RDY,
  output logic       PC_WRITE,
  output logic       IR_WRITE,
  output logic       MEM_RDEN1,
  output logic       MEM_RDEN2,
  output logic       MEM_WE2,
  output logic       RF_WE,
  output logic       CSR_WE,
  output logic       INT_TAKEN,
  output logic       MRET_EXEC,
  output logic [2:0] PC_SEL
);

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_MEM_WAIT,
    ST_WRITEBACK,
    ST_INTR
  } state_t;

  typedef enum logic [1:0] {
    MEM_NONE,
    MEM_LOAD,
    MEM_STORE
  } mem_kind_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] SEL_PC4    = 3'd0;
  localparam logic [2:0] SEL_JALR   = 3'd1;
  localparam logic [2:0] SEL_BRANCH = 3'd2;
  localparam logic [2:0] SEL_JAL    = 3'd3;
  localparam logic [2:0] SEL_MTVEC  = 3'd4;
  localparam logic [2:0] SEL_MEPC   = 3'd5;

  state_t    state, state_nxt;
  mem_kind_t mem_kind, mem_kind_nxt;
  logic      retire;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path infers a latch.
    PC_WRITE     = 1'b0;
    IR_WRITE     = 1'b0;
    MEM_RDEN1    = 1'b0;
    MEM_RDEN2    = 1'b0;
    MEM_WE2      = 1'b0;
    RF_WE        = 1'b0;
    CSR_WE       = 1'b0;
    INT_TAKEN    = 1'b0;
    MRET_EXEC    = 1'b0;
    PC_SEL       = SEL_PC4;
    state_nxt    = state;
    mem_kind_nxt = mem_kind;

    unique case (state)
      ST_FETCH: begin
        MEM_RDEN1 = 1'b1;
        if (MEM_RDY) begin
          IR_WRITE  = 1'b1;
          state_nxt = ST_DECODE;
        end
      end

      ST_DECODE: begin
        mem_kind_nxt = MEM_NONE;
        unique case (OPCODE)
          OP_LOAD: begin
            MEM_RDEN2    = 1'b1;
            mem_kind_nxt = MEM_LOAD;
            state_nxt    = ST_MEM_WAIT;
          end
          OP_STORE: begin
            MEM_WE2      = 1'b1;
            mem_kind_nxt = MEM_STORE;
            state_nxt    = ST_MEM_WAIT;
          end
          OP_OP, OP_IMM, OP_LUI, OP_AUIPC: begin
            RF_WE    = 1'b1;
            PC_WRITE = 1'b1;
          end
          OP_JAL: begin
            RF_WE    = 1'b1;
            PC_WRITE = 1'b1;
            PC_SEL   = SEL_JAL;
          end
          OP_JALR: begin
            RF_WE    = 1'b1;
            PC_WRITE = 1'b1;
            PC_SEL   = SEL_JALR;
          end
          OP_BRANCH: begin
            PC_WRITE = 1'b1;
            PC_SEL   = BR_TAKEN ? SEL_BRANCH : SEL_PC4;
          end
          OP_SYSTEM: begin
            PC_WRITE = 1'b1;
            if (FUNCT3 == 3'b000) begin
              MRET_EXEC = 1'b1;
              PC_SEL    = SEL_MEPC;
            end else begin
              RF_WE  = 1'b1;
              CSR_WE = 1'b1;
            end
          end
          // Unknown opcodes retire as a NOP so the core never wedges.
          default: PC_WRITE = 1'b1;
        endcase
      end

      ST_MEM_WAIT: begin
        unique case (mem_kind)
          MEM_LOAD: begin
            MEM_RDEN2 = 1'b1;
            if (MEM_RDY) state_nxt = ST_WRITEBACK;
          end
          MEM_STORE: begin
            MEM_WE2 = 1'b1;
            if (MEM_RDY) PC_WRITE = 1'b1;
          end
          default: state_nxt = ST_FETCH;
        endcase
      end

      ST_WRITEBACK: begin
        RF_WE    = 1'b1;
        PC_WRITE = 1'b1;
      end

      ST_INTR: begin
        PC_WRITE  = 1'b1;
        INT_TAKEN = 1'b1;
        PC_SEL    = SEL_MTVEC;
        state_nxt = ST_FETCH;
      end

      default: state_nxt = ST_FETCH;
    endcase

    // Interrupts are only taken between instructions, never after an mret.
    retire = PC_WRITE && (state != ST_INTR);
    if (retire) state_nxt = (INTR && MIE && !MRET_EXEC) ? ST_INTR : ST_FETCH;

    if (RST) begin
      PC_WRITE  = 1'b0;
      IR_WRITE  = 1'b0;
      MEM_RDEN1 = 1'b0;
      MEM_RDEN2 = 1'b0;
      MEM_WE2   = 1'b0;
      RF_WE     = 1'b0;
      CSR_WE    = 1'b0;
      INT_TAKEN = 1'b0;
      MRET_EXEC = 1'b0;
      PC_SEL    = SEL_PC4;
    end
  end

  // NOTE: reset is sampled on the clock edge here, so it belongs inside the
  // clocked block rather than in the sensitivity list.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= ST_FETCH;
      mem_kind <= MEM_NONE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      state    <= state_nxt;
      mem_kind <= mem_kind_nxt;
    end
  end

endmodule

// File: tb/tb_pc_ctrl_fsm.sv
// Directed and random stimulus for pc_ctrl_fsm, compared every cycle against
// an instruction-level model of the control sequence.
module tb_pc_ctrl_fsm;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       INTR = 1'b0;
  logic       MIE = 1'b0;
  logic [6:0] OPCODE = 7'd0;
  logic [2:0] FUNCT3 = 3'd0;
  logic       BR_TAKEN = 1'b0;
  logic       MEM_RDY = 1'b0;
  logic       PC_WRITE, IR_WRITE, MEM_RDEN1, MEM_RDEN2, MEM_WE2;
  logic       RF_WE, CSR_WE, INT_TAKEN, MRET_EXEC;
  logic [2:0] PC_SEL;

  pc_ctrl_fsm dut (
    .CLK(CLK), .RST(RST), .INTR(INTR), .MIE(MIE), .OPCODE(OPCODE),
    .FUNCT3(FUNCT3), .BR_TAKEN(BR_TAKEN), .MEM_RDY(MEM_RDY),
    .PC_WRITE(PC_WRITE), .IR_WRITE(IR_WRITE), .MEM_RDEN1(MEM_RDEN1),
    .MEM_RDEN2(MEM_RDEN2), .MEM_WE2(MEM_WE2), .RF_WE(RF_WE), .CSR_WE(CSR_WE),
    .INT_TAKEN(INT_TAKEN), .MRET_EXEC(MRET_EXEC), .PC_SEL(PC_SEL)
  );

  always #5 CLK = ~CLK;

  // Output vector layout: {PC_WRITE, IR_WRITE, RDEN1, RDEN2, WE2, RF_WE,
  // CSR_WE, INT_TAKEN, MRET_EXEC, PC_SEL[2:0]}
  localparam logic [11:0] O_PCW  = 12'h800;
  localparam logic [11:0] O_IRW  = 12'h400;
  localparam logic [11:0] O_RD1  = 12'h200;
  localparam logic [11:0] O_RD2  = 12'h100;
  localparam logic [11:0] O_WE2  = 12'h080;
  localparam logic [11:0] O_RFW  = 12'h040;
  localparam logic [11:0] O_CSR  = 12'h020;
  localparam logic [11:0] O_INT  = 12'h010;
  localparam logic [11:0] O_MRET = 12'h008;

  localparam logic [6:0] ADD  = 7'b0110011;
  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] BEQ  = 7'b1100011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111;
  localparam logic [6:0] SYS  = 7'b1110011;
  localparam logic [6:0] BAD  = 7'b1111111;

  logic [11:0] dut_vec;
  assign dut_vec = {PC_WRITE, IR_WRITE, MEM_RDEN1, MEM_RDEN2, MEM_WE2, RF_WE,
                    CSR_WE, INT_TAKEN, MRET_EXEC, PC_SEL};

  int n_checks = 0;
  int n_err = 0;
  logic [11:0] last_out;

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %03h expected %03h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- instruction-level model ----------------
  typedef enum {C_ALU, C_JAL, C_JALR, C_BR, C_MRET, C_CSR, C_NOP, C_LOAD, C_STORE} iclass_e;

  bit      m_have_ir = 0;  // instruction word captured
  bit      m_decoded = 0;  // decode cycle already spent (memory op in flight)
  bit      m_need_wb = 0;  // load data arrived, register write pending
  bit      m_irq     = 0;  // interrupt entry owed before next fetch
  iclass_e m_cls     = C_NOP;

  function automatic iclass_e classify(input logic [6:0] op, input logic [2:0] f3);
    case (op)
      7'b0000011: return C_LOAD;
      7'b0100011: return C_STORE;
      7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: return C_ALU;
      7'b1101111: return C_JAL;
      7'b1100111: return C_JALR;
      7'b1100011: return C_BR;
      7'b1110011: return (f3 == 3'd0) ? C_MRET : C_CSR;
      default:    return C_NOP;
    endcase
  endfunction

  function automatic logic [11:0] model_expect(input logic rst, input logic br, input logic rdy);
    if (rst) return 12'h000;
    if (m_irq) return O_PCW | O_INT | 12'd4;
    if (!m_have_ir) return O_RD1 | (rdy ? O_IRW : 12'h000);
    if (!m_decoded) begin
      case (m_cls)
        C_LOAD:  return O_RD2;
        C_STORE: return O_WE2;
        C_ALU:   return O_PCW | O_RFW;
        C_JAL:   return O_PCW | O_RFW | 12'd3;
        C_JALR:  return O_PCW | O_RFW | 12'd1;
        C_BR:    return O_PCW | (br ? 12'd2 : 12'd0);
        C_MRET:  return O_PCW | O_MRET | 12'd5;
        C_CSR:   return O_PCW | O_RFW | O_CSR;
        default: return O_PCW;
      endcase
    end
    if (m_need_wb) return O_PCW | O_RFW;
    if (m_cls == C_LOAD) return O_RD2;
    return O_WE2 | (rdy ? O_PCW : 12'h000);
  endfunction

  task automatic model_advance(input logic rst, input logic intr, input logic mie,
                               input logic [6:0] op, input logic [2:0] f3,
                               input logic rdy, input logic [11:0] exp_v);
    if (rst) begin
      m_have_ir = 0; m_decoded = 0; m_need_wb = 0; m_irq = 0;
    end else if (m_irq) begin
      m_irq = 0;
    end else if (exp_v[11]) begin
      m_have_ir = 0; m_decoded = 0; m_need_wb = 0;
      m_irq = intr && mie && !exp_v[3];
    end else if (!m_have_ir) begin
      if (rdy) begin
        m_have_ir = 1;
        m_cls = classify(op, f3);
      end
    end else if (!m_decoded) begin
      m_decoded = 1;
    end else if (m_cls == C_LOAD && rdy) begin
      m_need_wb = 1;
    end
  endtask

  // One clock cycle: drive, compare at the falling edge, advance model.
  task automatic step(input logic rst, input logic intr, input logic mie,
                      input logic [6:0] op, input logic [2:0] f3,
                      input logic br, input logic rdy);
    logic [11:0] exp_v;
    RST = rst; INTR = intr; MIE = mie; OPCODE = op; FUNCT3 = f3;
    BR_TAKEN = br; MEM_RDY = rdy;
    @(negedge CLK);
    last_out = dut_vec;
    exp_v = model_expect(rst, br, rdy);
    check("cycle", last_out, exp_v);
    @(posedge CLK);
    model_advance(rst, intr, mie, op, f3, rdy, exp_v);
    #1;
  endtask

  // Runs one instruction from FETCH; memory stalls start at the first
  // MEM_WAIT cycle. Returns cycles to completion (0 if budget expired).
  task automatic run_insn(input logic [6:0] op, input logic [2:0] f3, input logic br,
                          input int stalls, input logic intr, input logic mie,
                          output int cycles, output int rd2_wait,
                          output int rfwe_cnt, output int pcw_cnt);
    cycles = 0; rd2_wait = 0; rfwe_cnt = 0; pcw_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      step(1'b0, intr, mie, op, f3, br, !(k >= 2 && k < 2 + stalls));
      if (k >= 2 && last_out[8]) rd2_wait++;
      if (last_out[6]) rfwe_cnt++;
      if (last_out[11]) pcw_cnt++;
      if (last_out[11]) begin
        cycles = k + 1;
        break;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, rd2, rfw, pcw;
    logic [6:0] cur_op;
    logic [2:0] cur_f3;
    logic [6:0] op_tbl [10];
    op_tbl = '{ADD, 7'b0010011, 7'b0110111, 7'b0010111, LW, SW, BEQ, JAL, JALR, SYS};

    #1;
    step(1'b1, 1'b1, 1'b1, ADD, 3'd0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, LW, 3'd0, 1'b0, 1'b1);
    check("reset_outputs", last_out, 12'h000);

    step(1'b0, 1'b0, 1'b0, ADD, 3'd0, 1'b0, 1'b1);
    check("add_fetch", last_out, O_RD1 | O_IRW);
    step(1'b0, 1'b0, 1'b0, ADD, 3'd0, 1'b0, 1'b1);
    check("add_decode", last_out, O_PCW | O_RFW);

    run_insn(ADD, 3'd0, 1'b0, 0, 1'b0, 1'b0, cyc, rd2, rfw, pcw);
    check_int("add_latency", cyc, 2);

    run_insn(LW, 3'd2, 1'b0, 3, 1'b0, 1'b0, cyc, rd2, rfw, pcw);
    check_int("lw_stall_latency", cyc, 7);
    check_int("lw_stall_rden2_wait", rd2, 4);
    check_int("lw_rf_we_count", rfw, 1);
    check("lw_writeback", last_out, O_PCW | O_RFW);

    run_insn(LW, 3'd2, 1'b0, 0, 1'b0, 1'b0, cyc, rd2, rfw, pcw);
    check_int("lw_latency", cyc, 4);

    run_insn(BEQ, 3'd0, 1'b1, 0, 1'b0, 1'b0, cyc, rd2, rfw, pcw);
    check("beq_taken", last_out, O_PCW | 12'd2);
    check_int("beq_taken_rf_we", rfw, 0);
    run_insn(BEQ, 3'd0, 1'b0, 0, 1'b0, 1'b0, cyc, rd2, rfw, pcw);
    check("beq_not_taken", last_out, O_PCW);
    check_int("beq_pc_write_once", pcw, 1);

    run_insn(JAL, 3'd0, 1'b0, 0, 1'b0, 1'b0, cyc, rd2, rfw, pcw);
    check("jal", last_out, O_PCW | O_RFW | 12'd3);
    run_insn(JALR, 3'd0, 1'b0, 0, 1'b0, 1'b0, cyc, rd2, rfw, pcw);
    check("jalr", last_out, O_PCW | O_RFW | 12'd1);
    run_insn(SYS, 3'd1, 1'b0, 0, 1'b0, 1'b0, cyc, rd2, rfw, pcw);
    check("csrrw", last_out, O_PCW | O_RFW | O_CSR);
    run_insn(BAD, 3'd0, 1'b0, 0, 1'b0, 1'b0, cyc, rd2, rfw, pcw);
    check("unknown_nop", last_out, O_PCW);
    check_int("nop_latency", cyc, 2);

    run_insn(SW, 3'd2, 1'b0, 0, 1'b1, 1'b1, cyc, rd2, rfw, pcw);
    check_int("sw_latency", cyc, 3);
    check("sw_complete", last_out, O_PCW | O_WE2);
    step(1'b0, 1'b1, 1'b1, SW, 3'd2, 1'b0, 1'b1);
    check("intr_entry", last_out, O_PCW | O_INT | 12'd4);
    step(1'b0, 1'b1, 1'b1, SW, 3'd2, 1'b0, 1'b0);
    check("after_intr_fetch", last_out, O_RD1);

    run_insn(SW, 3'd2, 1'b0, 0, 1'b1, 1'b0, cyc, rd2, rfw, pcw);
    step(1'b0, 1'b1, 1'b0, ADD, 3'd0, 1'b0, 1'b0);
    check("mie_off_no_intr", last_out, O_RD1);

    run_insn(SYS, 3'd0, 1'b0, 0, 1'b1, 1'b1, cyc, rd2, rfw, pcw);
    check("mret", last_out, O_PCW | O_MRET | 12'd5);
    step(1'b0, 1'b1, 1'b1, ADD, 3'd0, 1'b0, 1'b0);
    check("mret_no_intr", last_out, O_RD1);

    step(1'b0, 1'b1, 1'b1, ADD, 3'd0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, ADD, 3'd0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, ADD, 3'd0, 1'b0, 1'b0);
    check("intr_dropped_no_entry", last_out, O_RD1);

    step(1'b0, 1'b0, 1'b0, LW, 3'd2, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, LW, 3'd2, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, ADD, 3'd2, 1'b0, 1'b0);
    check("lw_wait_ignores_opcode", last_out, O_RD2);
    step(1'b1, 1'b0, 1'b0, LW, 3'd2, 1'b0, 1'b1);
    check("reset_mid_wait", last_out, 12'h000);
    step(1'b0, 1'b0, 1'b0, LW, 3'd2, 1'b0, 1'b0);
    check("post_reset_fetch", last_out, O_RD1);

    cur_op = ADD;
    cur_f3 = 3'd0;
    for (int i = 0; i < 4000; i++) begin
      logic [6:0] op_d;
      logic [2:0] f3_d;
      if (!m_have_ir) begin
        cur_op = ($urandom_range(0, 9) == 0) ? 7'($urandom) : op_tbl[$urandom_range(0, 9)];
        cur_f3 = $urandom_range(0, 1) ? 3'd0 : 3'($urandom);
      end
      op_d = cur_op;
      f3_d = cur_f3;
      if (m_have_ir && m_decoded) begin
        op_d = 7'($urandom);
        f3_d = 3'($urandom);
      end
      step($urandom_range(0, 99) == 0, $urandom_range(0, 2) == 0, 1'($urandom),
           op_d, f3_d, 1'($urandom), $urandom_range(0, 9) < 7);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
